msg_checker: RTL and testbench

Sequential reader for the decrypted-message memory in the RC4 datapath. After the decryptor fills `d_memory`, the block reads every byte in order and checks that each one is a legal plaintext character (lowercase `a`–`z` or space). It reports pass/fail, the first offending address and the number of legal bytes seen. A key-search controller uses it to accept or reject a candidate `secret_key`.

---
 rtl/rc4_pkg.sv | 18 +
 rtl/char_is_legal.sv | 14 +
 rtl/msg_checker.sv | 118 +++++++++++
 tb/tb_msg_checker.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared constants and types for the RC4 datapath: message geometry, the
// plaintext character set and the message-checker state encoding.
package rc4_pkg;

  localparam int MSG_LEN = 32;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } msg_chk_state_t;

endpackage

// File: rtl/char_is_legal.sv
// Combinational plaintext classifier: space or lowercase a..z is legal.
// Shared with the key-search early-abort logic.
module char_is_legal
  import rc4_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       legal_o
);

  // Legal iff space or within the inclusive lowercase range.
  assign legal_o = (char_i == CHAR_SPACE) ||
                   ((char_i >= CHAR_LO) && (char_i <= CHAR_HI));

endmodule

// File: rtl/msg_checker.sv
// Sequential reader for the decrypted-message memory. Walks d_memory from
// address 0, waits out the read latency for every byte, and stops at the
// first illegal character or after the last byte. Reports pass/fail, the
// first offending address and the number of legal bytes seen.
module msg_checker #(
  parameter int MSG_LEN  = rc4_pkg::MSG_LEN,
  parameter int ADDR_W   = 5,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,   // active-high, synchronous
  input  logic              start,
  output logic [ADDR_W-1:0] address,
  input  logic [7:0]        q,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W:0]   valid_count
);

  import rc4_pkg::*;

  // The wait counter only has to hold READ_LAT-1.
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0]  WAIT_RELOAD = CNT_W'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(MSG_LEN - 1);
  localparam logic [ADDR_W:0]   VC_ONE      = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

  msg_chk_state_t    state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [ADDR_W:0]   valid_cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              q_legal;

  char_is_legal u_char_is_legal (
    .char_i  (q),
    .legal_o (q_legal)
  );

  // Checker FSM with its wait, address and valid counters; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      fail_addr_q <= '0;
      valid_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q      <= '0;
            valid_cnt_q <= '0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            cnt_q       <= WAIT_RELOAD;
            busy_q      <= 1'b1;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Counter starts at READ_LAT-1, so WAIT lasts exactly READ_LAT cycles.
          if (cnt_q == '0) begin
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_CHECK: begin
          if (!q_legal) begin
            // Early exit: later bytes are never read.
            fail_addr_q <= addr_q;
            pass_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end else if (addr_q == LAST_ADDR) begin
            // Address stays at the last byte rather than wrapping.
            valid_cnt_q <= valid_cnt_q + VC_ONE;
            pass_q      <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            valid_cnt_q <= valid_cnt_q + VC_ONE;
            addr_q      <= addr_q + ADDR_ONE;
            cnt_q       <= WAIT_RELOAD;
            state_q     <= ST_WAIT;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign address     = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_addr   = fail_addr_q;
  assign valid_count = valid_cnt_q;

endmodule

// File: tb/tb_msg_checker.sv
// Self-checking bench for msg_checker: a 2-cycle-latency d_memory model,
// a behavioural timeline model of the check, directed scenarios with
// literal expectations and a randomized message sweep.
module tb_msg_checker;

  localparam int MSG_LEN  = 32;
  localparam int ADDR_W   = 5;
  localparam int READ_LAT = 2;
  localparam int BYTE_CYC = READ_LAT + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] address;
  logic [7:0]        q;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W-1:0] fail_addr;
  logic [ADDR_W:0]   valid_count;

  msg_checker #(
    .MSG_LEN  (MSG_LEN),
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .address     (address),
    .q           (q),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_addr   (fail_addr),
    .valid_count (valid_count)
  );

  always #5 clk = ~clk;

  // d_memory: two register stages between address and q
  logic [7:0] mem [MSG_LEN];
  logic [7:0] q_s1;
  always @(posedge clk) begin
    q_s1 <= mem[address];
    q    <= q_s1;
  end

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  int E        = 0;     // edge count just before the start-sampling edge
  int max_addr = 0;
  bit cmp_en   = 1'b0;

  always @(posedge clk) edges++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  // ---------------- behavioural model ----------------
  // m_c counts edges since the start-sampling edge; m_D is the cycle of done.
  int m_active = 0, m_c = 0, m_D = 0, m_last = 0, m_V = 0, m_pass = 0, m_fail = 0;
  int h_pass = 0, h_fail = 0, h_vc = 0, h_addr = 0;

  always @(posedge clk) begin
    int k;
    if (reset_n === 1'b1) begin
      m_active = 0;
      h_pass = 0; h_fail = 0; h_vc = 0; h_addr = 0;
    end else if (m_active == 0) begin
      if (start === 1'b1) begin
        k = -1;
        for (int i = 0; i < MSG_LEN; i++)
          if (k < 0 && !legal(mem[i])) k = i;
        m_active = 1;
        m_c = 0;
        if (k < 0) begin
          m_pass = 1; m_fail = 0; m_V = MSG_LEN; m_last = MSG_LEN - 1;
          m_D = MSG_LEN * BYTE_CYC + 1;
        end else begin
          m_pass = 0; m_fail = k; m_V = k; m_last = k;
          m_D = (k + 1) * BYTE_CYC + 1;
        end
      end
    end else begin
      m_c++;
      if (m_c == m_D) begin
        m_active = 0;
        h_pass = m_pass; h_fail = m_fail; h_vc = m_V; h_addr = m_last;
      end
    end
  end

  // Compare the DUT against the model on every cycle.
  always @(negedge clk) begin
    int bi;
    if (cmp_en) begin
      if (m_active != 0) begin
        bi = m_c / BYTE_CYC;
        chk("busy",        busy,        1);
        chk("done",        done,        (m_c == m_D - 1) ? 1 : 0);
        chk("address",     address,     (bi < m_last) ? bi : m_last);
        chk("valid_count", valid_count, (bi < m_V) ? bi : m_V);
        chk("pass",        pass,        (m_c == m_D - 1) ? m_pass : 0);
        chk("fail_addr",   fail_addr,   (m_c == m_D - 1) ? m_fail : 0);
      end else begin
        chk("busy_idle",        busy,        0);
        chk("done_idle",        done,        0);
        chk("address_idle",     address,     h_addr);
        chk("valid_count_idle", valid_count, h_vc);
        chk("pass_idle",        pass,        h_pass);
        chk("fail_addr_idle",   fail_addr,   h_fail);
      end
      if (busy === 1'b1 && int'(address) > max_addr) max_addr = int'(address);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    E = edges;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done; returns its cycle number relative to the start edge.
  task automatic wait_done(input bit rnd_start, output int cyc);
    cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = edges - E;
        break;
      end
      start = (rnd_start && busy === 1'b1 && $urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    if (cyc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < MSG_LEN; i++) mem[i] = v;
  endtask

  function automatic logic [7:0] rand_char(input int illegal_pct);
    logic [7:0] b;
    if ($urandom_range(0, 99) < illegal_pct) begin
      do b = 8'($urandom_range(0, 255)); while (legal(b));
    end else if ($urandom_range(0, 5) == 0) begin
      b = 8'h20;
    end else begin
      b = 8'(8'h61 + $urandom_range(0, 25));
    end
    return b;
  endfunction

  logic [7:0] bvals [7] = '{8'h1F, 8'h20, 8'h21, 8'h60, 8'h61, 8'h7A, 8'h7B};
  bit         bpass [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int dc, e1, e2;
    reset_n = 1'b1;
    start   = 1'b0;
    fill(8'h61);
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_busy",  busy,        0);
    chk("rst_done",  done,        0);
    chk("rst_pass",  pass,        0);
    chk("rst_faddr", fail_addr,   0);
    chk("rst_vc",    valid_count, 0);
    chk("rst_addr",  address,     0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);

    // All legal
    pulse_start();
    wait_done(1'b0, dc);
    chk("all_done_cycle", dc, 97);
    chk("all_pass", pass, 1);
    chk("all_vc", valid_count, 32);
    chk("all_faddr", fail_addr, 0);
    repeat (2) @(negedge clk);

    // Early fail at byte 5
    mem[5] = 8'h41;
    max_addr = 0;
    pulse_start();
    wait_done(1'b0, dc);
    chk("early_done_cycle", dc, 19);
    chk("early_pass", pass, 0);
    chk("early_faddr", fail_addr, 5);
    chk("early_vc", valid_count, 5);
    repeat (3) @(negedge clk);
    chk("early_max_addr", max_addr, 5);
    mem[5] = 8'h61;

    // Boundary sweep on the last byte
    for (int i = 0; i < 7; i++) begin
      fill(8'h61);
      mem[31] = bvals[i];
      pulse_start();
      wait_done(1'b0, dc);
      chk("bnd_done_cycle", dc, 97);
      chk("bnd_pass", pass, bpass[i]);
      chk("bnd_faddr", fail_addr, bpass[i] ? 0 : 31);
      chk("bnd_vc", valid_count, bpass[i] ? 32 : 31);
      @(negedge clk);
    end

    // Reset at cycle 40
    fill(8'h20);
    pulse_start();
    while (edges - E < 40) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy",  busy,        0);
    chk("midrst_done",  done,        0);
    chk("midrst_pass",  pass,        0);
    chk("midrst_faddr", fail_addr,   0);
    chk("midrst_vc",    valid_count, 0);
    chk("midrst_addr",  address,     0);
    reset_n = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_done(1'b0, dc);
    chk("post_rst_done_cycle", dc, 97);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_vc", valid_count, 32);

    // Start pulsed at cycle 10 while busy
    @(negedge clk);
    pulse_start();
    while (edges - E < 9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, dc);
    chk("busy_start_done_cycle", dc, 97);
    repeat (3) @(negedge clk);
    chk("busy_start_not_queued", busy, 0);

    // Start held high: back-to-back checks
    @(negedge clk);
    start = 1'b1;
    E = edges;
    wait_done(1'b0, dc);
    start = 1'b1;
    e1 = edges;
    e2 = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        e2 = edges;
        break;
      end
    end
    start = 1'b0;
    chk("held_first_done_cycle", dc, 97);
    chk("held_gap", e2 - e1, 98);

    // Randomized messages with spurious start pulses while busy
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      for (int i = 0; i < MSG_LEN; i++) mem[i] = rand_char((t % 3 == 0) ? 0 : 3);
      pulse_start();
      wait_done(1'b1, dc);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
